// File: rtl/rs_station_if.sv
// Dispatch and issue handshake bundle for the reservation station.
// master = map-table/FU side, slave = reservation station.
interface rs_station_if #(
  parameter int TAG_W = 5,
  parameter int OP_W  = 8
);
  logic             disp_valid;
  logic             disp_ready;
  logic [TAG_W-1:0] disp_rob_tag;
  logic [OP_W-1:0]  disp_op;
  logic [TAG_W-1:0] disp_tag_a;
  logic             disp_tplus_a;
  logic [TAG_W-1:0] disp_tag_b;
  logic             disp_tplus_b;
  logic             issue_valid;
  logic             issue_ready;
  logic [TAG_W-1:0] issue_rob_tag;
  logic [OP_W-1:0]  issue_op;
  logic [TAG_W-1:0] issue_tag_a;
  logic [TAG_W-1:0] issue_tag_b;

  modport master (
    output disp_valid, disp_rob_tag, disp_op,
    output disp_tag_a, disp_tplus_a,
    output disp_tag_b, disp_tplus_b,
    input  disp_ready,
    input  issue_valid, issue_rob_tag, issue_op,
    input  issue_tag_a, issue_tag_b,
    output issue_ready
  );

  modport slave (
    input  disp_valid, disp_rob_tag, disp_op,
    input  disp_tag_a, disp_tplus_a,
    input  disp_tag_b, disp_tplus_b,
    output disp_ready,
    output issue_valid, issue_rob_tag, issue_op,
    output issue_tag_a, issue_tag_b,
    input  issue_ready
  );
endinterface

// File: rtl/rs_station.sv
// Reservation station: CDB wakeup, age-matrix oldest-first issue.
// Entries allocate lowest-free-index; age order lives in older[][].
module rs_station #(
  parameter  int N_ENT = 8,
  parameter  int TAG_W = 5,
  parameter  int OP_W  = 8,
  localparam int IDX_W = $clog2(N_ENT),
  localparam int CNT_W = IDX_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  output logic [CNT_W-1:0] count,
  rs_station_if.slave      bus
);

  logic [N_ENT-1:0] busy;
  logic [N_ENT-1:0] rdy_a;
  logic [N_ENT-1:0] rdy_b;
  logic [N_ENT-1:0] elig;
  logic [N_ENT-1:0] blocked;
  logic [N_ENT-1:0] grant;
  logic [N_ENT-1:0] older [N_ENT];
  logic [OP_W-1:0]  op_q  [N_ENT];
  logic [TAG_W-1:0] rob_q [N_ENT];
  logic [TAG_W-1:0] ta_q  [N_ENT];
  logic [TAG_W-1:0] tb_q  [N_ENT];

  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] sel_idx;
  logic             disp_ready;
  logic             disp_fire;
  logic             issue_fire;
  logic             wake;
  logic             new_rdy_a;
  logic             new_rdy_b;
  logic [TAG_W-1:0] i_rob;
  logic [OP_W-1:0]  i_op;
  logic [TAG_W-1:0] i_ta;
  logic [TAG_W-1:0] i_tb;

  assign disp_ready = !reset && (count < CNT_W'(N_ENT));
  assign disp_fire  = bus.disp_valid && disp_ready;
  assign wake       = cdb_valid && (cdb_tag != '0);
  assign elig       = busy & rdy_a & rdy_b & {N_ENT{!reset}};
  assign issue_fire = bus.issue_valid && bus.issue_ready;

  assign new_rdy_a = (bus.disp_tag_a == '0) || bus.disp_tplus_a
                   || (wake && cdb_tag == bus.disp_tag_a);
  assign new_rdy_b = (bus.disp_tag_b == '0) || bus.disp_tplus_b
                   || (wake && cdb_tag == bus.disp_tag_b);

  assign bus.disp_ready    = disp_ready;
  assign bus.issue_valid   = |elig;
  assign bus.issue_rob_tag = i_rob;
  assign bus.issue_op      = i_op;
  assign bus.issue_tag_a   = i_ta;
  assign bus.issue_tag_b   = i_tb;

  // Lowest-index free entry receives the next dispatch.
  always_comb begin
    free_idx = '0;
    for (int i = N_ENT - 1; i >= 0; i--) begin
      if (!busy[i]) free_idx = IDX_W'(i);
    end
  end

  // An eligible entry wins unless some older entry is also eligible.
  always_comb begin
    blocked = '0;
    for (int i = 0; i < N_ENT; i++) begin
      for (int j = 0; j < N_ENT; j++) begin
        if (elig[j] && older[j][i]) blocked[i] = 1'b1;
      end
    end
    grant = elig & ~blocked;
  end

  // One-hot AND-OR mux of the winning entry; all zero when idle.
  always_comb begin
    sel_idx = '0;
    i_rob   = '0;
    i_op    = '0;
    i_ta    = '0;
    i_tb    = '0;
    for (int i = 0; i < N_ENT; i++) begin
      if (grant[i]) begin
        sel_idx = IDX_W'(i);
        i_rob   = i_rob | rob_q[i];
        i_op    = i_op | op_q[i];
        i_ta    = i_ta | ta_q[i];
        i_tb    = i_tb | tb_q[i];
      end
    end
  end

  // Entry state, age matrix and occupancy count.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy  <= '0;
      rdy_a <= '0;
      rdy_b <= '0;
      count <= '0;
      for (int i = 0; i < N_ENT; i++) begin
        older[i] <= '0;
        op_q[i]  <= '0;
        rob_q[i] <= '0;
        ta_q[i]  <= '0;
        tb_q[i]  <= '0;
      end
    end else if (flush) begin
      busy  <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < N_ENT; i++) begin
        if (busy[i] && wake && ta_q[i] == cdb_tag) rdy_a[i] <= 1'b1;
        if (busy[i] && wake && tb_q[i] == cdb_tag) rdy_b[i] <= 1'b1;
      end
      if (issue_fire) busy[sel_idx] <= 1'b0;
      if (disp_fire) begin
        busy[free_idx]  <= 1'b1;
        op_q[free_idx]  <= bus.disp_op;
        rob_q[free_idx] <= bus.disp_rob_tag;
        ta_q[free_idx]  <= bus.disp_tag_a;
        tb_q[free_idx]  <= bus.disp_tag_b;
        rdy_a[free_idx] <= new_rdy_a;
        rdy_b[free_idx] <= new_rdy_b;
        for (int k = 0; k < N_ENT; k++) begin
          older[k][free_idx] <= busy[k];
        end
        older[free_idx] <= '0;
      end
      count <= count + CNT_W'(disp_fire) - CNT_W'(issue_fire);
    end
  end

endmodule

// File: tb/tb_rs_station.sv
// Bench for rs_station: queue-ordered reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_rs_station;

  logic       clock;
  logic       reset;
  logic       flush;
  logic       cdb_valid;
  logic [4:0] cdb_tag;
  logic [3:0] count;

  int vecs;
  int errs;

  rs_station_if #(.TAG_W(5), .OP_W(8)) bus ();

  rs_station dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .count     (count),
    .bus       (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int rob;
    int op;
    int ta;
    bit ra;
    int tb;
    bit rb;
  } ent_t;

  ent_t q[$];

  task automatic check(string name, int act, int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic int oldest_ready();
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].ra && q[i].rb) return i;
    end
    return -1;
  endfunction

  // Model update on each edge, from pre-edge model state and inputs.
  initial begin
    forever begin
      @(posedge clock);
      if (reset || flush) begin
        q.delete();
      end else begin
        int  sel;
        bit  full;
        bit  wk;
        int  ct;
        sel  = oldest_ready();
        full = (q.size() >= 8);
        wk   = cdb_valid && cdb_tag != 0;
        ct   = int'(cdb_tag);
        for (int i = 0; i < q.size(); i++) begin
          if (wk && q[i].ta == ct) q[i].ra = 1'b1;
          if (wk && q[i].tb == ct) q[i].rb = 1'b1;
        end
        if (sel >= 0 && bus.issue_ready) q.delete(sel);
        if (bus.disp_valid && !full) begin
          ent_t e;
          e.rob = int'(bus.disp_rob_tag);
          e.op  = int'(bus.disp_op);
          e.ta  = int'(bus.disp_tag_a);
          e.tb  = int'(bus.disp_tag_b);
          e.ra  = (e.ta == 0) || bus.disp_tplus_a || (wk && ct == e.ta);
          e.rb  = (e.tb == 0) || bus.disp_tplus_b || (wk && ct == e.tb);
          q.push_back(e);
        end
      end
    end
  end

  // Compare DUT outputs with the model in the middle of every cycle.
  initial begin
    forever begin
      @(negedge clock);
      begin
        int sel;
        int ev;
        int er, eo, ea, eb;
        sel = reset ? -1 : oldest_ready();
        ev  = (sel >= 0);
        er  = ev ? q[sel].rob : 0;
        eo  = ev ? q[sel].op  : 0;
        ea  = ev ? q[sel].ta  : 0;
        eb  = ev ? q[sel].tb  : 0;
        check("m_valid", int'(bus.issue_valid), ev);
        check("m_rob", int'(bus.issue_rob_tag), er);
        check("m_op", int'(bus.issue_op), eo);
        check("m_tag_a", int'(bus.issue_tag_a), ea);
        check("m_tag_b", int'(bus.issue_tag_b), eb);
        check("m_count", int'(count), q.size());
        check("m_dready", int'(bus.disp_ready),
              (!reset && q.size() < 8) ? 1 : 0);
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.disp_valid = 1'b0;
    cdb_valid      = 1'b0;
    cdb_tag        = '0;
    flush          = 1'b0;
  endtask

  task automatic disp(input int rob, input int op,
                      input int ta, input bit pa,
                      input int tb, input bit pb);
    bus.disp_valid   = 1'b1;
    bus.disp_rob_tag = 5'(rob);
    bus.disp_op      = 8'(op);
    bus.disp_tag_a   = 5'(ta);
    bus.disp_tplus_a = pa;
    bus.disp_tag_b   = 5'(tb);
    bus.disp_tplus_b = pb;
  endtask

  task automatic cdb(input int t);
    cdb_valid = 1'b1;
    cdb_tag   = 5'(t);
  endtask

  initial begin
    vecs  = 0;
    errs  = 0;
    reset = 1'b1;
    bus.issue_ready = 1'b0;
    disp(0, 0, 0, 0, 0, 0);
    idle();
    cyc();
    cyc();
    check("rst_valid", int'(bus.issue_valid), 0);
    check("rst_rob", int'(bus.issue_rob_tag), 0);
    check("rst_dready", int'(bus.disp_ready), 0);
    check("rst_count", int'(count), 0);
    reset = 1'b0;
    cyc();
    check("post_rst_dready", int'(bus.disp_ready), 1);

    // ready dispatch issues next cycle
    bus.issue_ready = 1'b1;
    disp(9, 'h11, 0, 0, 0, 0);
    cyc();
    idle();
    check("t1_valid", int'(bus.issue_valid), 1);
    check("t1_rob", int'(bus.issue_rob_tag), 9);
    check("t1_op", int'(bus.issue_op), 'h11);
    check("t1_count1", int'(count), 1);
    cyc();
    check("t1_count0", int'(count), 0);
    check("t1_idle", int'(bus.issue_valid), 0);

    // wakeup from CDB
    disp(3, 'h22, 1, 0, 0, 0);
    cyc();
    idle();
    check("t2_wait", int'(bus.issue_valid), 0);
    cyc();
    cyc();
    cdb(1);
    cyc();
    idle();
    check("t2_valid", int'(bus.issue_valid), 1);
    check("t2_tag_a", int'(bus.issue_tag_a), 1);
    check("t2_rob", int'(bus.issue_rob_tag), 3);
    cyc();
    check("t2_count0", int'(count), 0);

    // same-edge CDB bypass at dispatch
    disp(10, 'h33, 0, 0, 2, 0);
    cdb(2);
    cyc();
    idle();
    check("t3_valid", int'(bus.issue_valid), 1);
    check("t3_rob", int'(bus.issue_rob_tag), 10);
    check("t3_tag_b", int'(bus.issue_tag_b), 2);
    cyc();

    // age order among simultaneous wakeups
    disp(4, 'h44, 7, 0, 0, 0);
    cyc();
    disp(5, 'h45, 7, 0, 0, 0);
    cyc();
    disp(6, 'h46, 7, 0, 0, 0);
    cyc();
    idle();
    check("t4_wait", int'(bus.issue_valid), 0);
    cdb(7);
    cyc();
    idle();
    check("t4_rob4", int'(bus.issue_rob_tag), 4);
    check("t4_cnt3", int'(count), 3);
    cyc();
    check("t4_rob5", int'(bus.issue_rob_tag), 5);
    cyc();
    check("t4_rob6", int'(bus.issue_rob_tag), 6);
    cyc();
    check("t4_empty", int'(bus.issue_valid), 0);
    check("t4_cnt0", int'(count), 0);

    // fill, backpressure, no issue-to-dispatch bypass
    bus.issue_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      disp(11 + i, 'h50 + i, 20, 0, 0, 0);
      cyc();
    end
    idle();
    check("t5_full_dready", int'(bus.disp_ready), 0);
    check("t5_full_cnt", int'(count), 8);
    disp(25, 'h60, 0, 0, 0, 0);
    cdb(20);
    cyc();
    idle();
    check("t5_reject_cnt", int'(count), 8);
    for (int h = 0; h < 3; h++) begin
      check("t5_hold_rob", int'(bus.issue_rob_tag), 11);
      cyc();
    end
    bus.issue_ready = 1'b1;
    disp(26, 'h61, 0, 0, 0, 0);
    cyc();
    idle();
    check("t5_after_cnt", int'(count), 7);
    check("t5_after_dready", int'(bus.disp_ready), 1);
    for (int k = 0; k < 7; k++) begin
      check("t5_drain_rob", int'(bus.issue_rob_tag), 12 + k);
      cyc();
    end
    check("t5_drained", int'(count), 0);

    // older entry waking up takes over a stalled selection
    bus.issue_ready = 1'b0;
    disp(19, 'h70, 21, 0, 0, 0);
    cyc();
    disp(27, 'h71, 0, 0, 0, 1);
    cyc();
    idle();
    check("t5b_young", int'(bus.issue_rob_tag), 27);
    cdb(21);
    cyc();
    idle();
    check("t5b_old", int'(bus.issue_rob_tag), 19);
    bus.issue_ready = 1'b1;
    cyc();
    check("t5b_next", int'(bus.issue_rob_tag), 27);
    cyc();
    check("t5b_cnt0", int'(count), 0);

    // flush drops a same-cycle dispatch
    bus.issue_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      disp(1 + i, 'h80 + i, 22, 0, 0, 0);
      cyc();
    end
    idle();
    check("t6_cnt5", int'(count), 5);
    flush = 1'b1;
    disp(30, 'h90, 0, 0, 0, 0);
    cyc();
    idle();
    check("t6_cnt0", int'(count), 0);
    check("t6_valid", int'(bus.issue_valid), 0);
    bus.issue_ready = 1'b1;
    cyc();
    check("t6_never", int'(bus.issue_valid), 0);

    // reset mid-operation discards a pending issue
    bus.issue_ready = 1'b0;
    disp(8, 'hA0, 0, 0, 0, 0);
    cyc();
    idle();
    check("t7_pending", int'(bus.issue_valid), 1);
    reset = 1'b1;
    cyc();
    check("t7_rst_valid", int'(bus.issue_valid), 0);
    check("t7_rst_rob", int'(bus.issue_rob_tag), 0);
    check("t7_rst_dready", int'(bus.disp_ready), 0);
    reset = 1'b0;
    bus.issue_ready = 1'b1;
    cyc();
    check("t7_dready", int'(bus.disp_ready), 1);
    check("t7_cnt", int'(count), 0);
    check("t7_valid", int'(bus.issue_valid), 0);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
